const_imm_fetch: RTL
====================

# const_imm_fetch

Sequencer for the `*.const` instruction family (`i32.const`, `i64.const`, `f32.const`, `f64.const`) inside `cpu`. The decode stage starts it once the opcode byte has been read. The block then owns the byte-wide instruction ROM read port, fetches and assembles the immediate (signed LEB128 or little-endian IEEE bytes), pushes the 64-bit value onto the operand stack through a valid/ready handshake, and returns the updated PC to decode.

## Interface
- `MAX_PC_W`, default 32: width of the PC and ROM byte address.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `opcode`  in  8  const opcode, sampled with `start`.
- `pc_in`  in  MAX_PC_W  address of the opcode byte, sampled with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `rom_rd`  out  1  ROM read strobe.
- `rom_addr`  out  MAX_PC_W  ROM byte address.
- `rom_data`  in  8  ROM data, valid exactly 1 cycle after `rom_rd`.
- `push_valid`  out  1  stack push request.
- `push_data`  out  64  value to push.
- `push_ready`  in  1  stack accepts the push.
- `done`  out  1  one-cycle completion pulse.
- `pc_out`  out  MAX_PC_W  next-instruction PC, valid while `done` is high.
- `trap`  out  3  trap code, valid while `done` is high; `TRAP_NONE` otherwise.

## Operation
- States: IDLE, FETCH, PUSH, FINISH.
- **IDLE**
  - Valid opcode with `start`: latch the operation, set `ptr = pc_in + 1`, go to FETCH.
  - Invalid opcode with `start`: go to FINISH with `TRAP_BAD_OPCODE` and issue no ROM reads.
- **FETCH**
  - Assert `rom_rd` with `rom_addr = ptr` every cycle; increment `ptr`.
  - Each returned byte is consumed the following cycle.
  - `f32`: consume exactly 4 bytes. `f64`: consume exactly 8 bytes. Bytes are little-endian.
  - `i32` / `i64`: accumulate 7 bits per byte at shift `7*k`. Stop on the first byte with bit 7 = 0, then sign-extend from bit `7*(k+1)-1`.
  - The one speculative read issued after the terminating LEB byte is discarded. ROM reads have no side effects.
- **Result widths**
  - `i32`: low 32 bits of the sign-extended value; upper 32 bits zero.
  - `f32`: raw bits in [31:0]; upper 32 bits zero.
  - `i64` and `f64`: full 64 bits.
- **PUSH**: hold `push_valid` and `push_data` stable until `push_ready`. On the handshake cycle go to FINISH.
- **FINISH**: pulse `done` for one cycle, drive `pc_out = pc_in + 1 + N` (N = bytes consumed) and `trap`, then return to IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0; `trap = TRAP_NONE`; state IDLE.
- `reset` asserted in any state returns the block to IDLE next cycle. Any in-flight push is dropped and `busy` is cleared.
- Cycle timeline, with `start` accepted in cycle 0:
  - ROM reads issue in cycles 1..N.
  - Bytes are consumed in cycles 2..N+1.
  - `push_valid` is first high in cycle N+2.
  - With `push_ready` already high: `done` in cycle N+3.
- Examples:
  - `f64`: `push_valid` @10, `done` @11.
  - Single-byte LEB: `push_valid` @3, `done` @4.
- Each stall cycle on `push_ready` delays `done` by one cycle.

## Configuration
- `CONST_LEB_CHECK_EN` defined:
  - An `i32` LEB longer than 5 bytes or an `i64` LEB longer than 10 bytes ends with `TRAP_MALFORMED_LEB`, no push, and `pc_out` = address after the last byte consumed.
  - Unused high bits of the final byte must equal the sign bit; otherwise the same trap is raised.
- Not defined: fetch stops after 5 (`i32`) or 10 (`i64`) bytes regardless of bit 7, unused bits are ignored, and no trap is raised.

## Structure
- Shared `cpu_pkg` holds:
  - Opcode constants: `OP_I32_CONST` = 8'h41, `OP_I64_CONST` = 8'h42, `OP_F32_CONST` = 8'h43, `OP_F64_CONST` = 8'h44.
  - Trap codes: `TRAP_NONE` = 0, `TRAP_BAD_OPCODE` = 1, `TRAP_MALFORMED_LEB` = 2.
  - The state encoding.
- Sub-module `leb128_accum` contains the byte-serial accumulator, sign extension, and the length/overflow check under `CONST_LEB_CHECK_EN`.

## Test plan
- `f64.const`, ROM bytes 00 00 00 00 00 00 00 C0 at `pc_in + 1` = 1, `push_ready` = 1 → `push_data` = 64'hC000000000000000 @10; `done` @11; `pc_out` = 9; `trap` = 0.
- `i32.const`, bytes 7F → `push_data` = 64'h00000000FFFFFFFF; `done` @4; `pc_out` = `pc_in` + 2.
- `i64.const`, bytes E5 8E 26 → `push_data` = 64'd624485; `pc_out` = `pc_in` + 4.
- `f32.const` 00 00 80 3F with `push_ready` low for 3 cycles → `push_valid` and `push_data` = 64'h3F800000 held stable; `done` 3 cycles later than with no stall.
- `opcode` 8'h45 → no `rom_rd`; `done` @1 with `trap` = 1. Separately, `reset` asserted during FETCH → `busy` = 0 and all outputs 0 next cycle.
- With `CONST_LEB_CHECK_EN`, `i32` bytes FF FF FF FF FF 01 → `trap` = 2, no push.

Source files
------------

// File: rtl/const_imm_fetch_pkg.sv
// cpu_pkg: opcodes, trap codes, FSM states and decode helpers
// shared by the const-immediate sequencer and its accumulator.
package cpu_pkg;

    localparam logic [7:0] OP_I32_CONST = 8'h41;
    localparam logic [7:0] OP_I64_CONST = 8'h42;
    localparam logic [7:0] OP_F32_CONST = 8'h43;
    localparam logic [7:0] OP_F64_CONST = 8'h44;

    localparam logic [2:0] TRAP_NONE          = 3'd0;
    localparam logic [2:0] TRAP_BAD_OPCODE    = 3'd1;
    localparam logic [2:0] TRAP_MALFORMED_LEB = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PUSH,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        K_I32,
        K_I64,
        K_F32,
        K_F64
    } kind_t;

    function automatic logic op_valid(input logic [7:0] op);
        return op inside {OP_I32_CONST, OP_I64_CONST,
                          OP_F32_CONST, OP_F64_CONST};
    endfunction

    function automatic kind_t op_kind(input logic [7:0] op);
        unique case (1'b1)
            op == OP_I64_CONST: return K_I64;
            op == OP_F32_CONST: return K_F32;
            op == OP_F64_CONST: return K_F64;
            default:            return K_I32;
        endcase
    endfunction

    // Maximum immediate bytes per kind (LEB cap or fixed width).
    function automatic logic [3:0] byte_limit(input kind_t k);
        unique case (k)
            K_I32: return 4'd5;
            K_I64: return 4'd10;
            K_F32: return 4'd4;
            K_F64: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/const_imm_fetch_if.sv
// const_imm_fetch_if: decode request/response, ROM read port and
// stack push handshake. slave = sequencer side, master = environment.
interface const_imm_fetch_if #(
    parameter int MAX_PC_W = 32
);
    logic                start;
    logic [7:0]          opcode;
    logic [MAX_PC_W-1:0] pc_in;
    logic                busy;
    logic                rom_rd;
    logic [MAX_PC_W-1:0] rom_addr;
    logic [7:0]          rom_data;
    logic                push_valid;
    logic [63:0]         push_data;
    logic                push_ready;
    logic                done;
    logic [MAX_PC_W-1:0] pc_out;
    logic [2:0]          trap;

    modport master (
        output start, opcode, pc_in, rom_data, push_ready,
        input  busy, rom_rd, rom_addr, push_valid, push_data,
        input  done, pc_out, trap
    );

    modport slave (
        input  start, opcode, pc_in, rom_data, push_ready,
        output busy, rom_rd, rom_addr, push_valid, push_data,
        output done, pc_out, trap
    );
endinterface

// File: rtl/const_imm_fetch_accum.sv
// leb128_accum: byte-serial immediate assembly (LEB128 or LE raw).
// Ports: clr/en control, kind, din byte; last, bad, formatted result.
// CONST_LEB_CHECK_EN enables the overlong / unused-bit LEB check.
module leb128_accum
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  kind_t       kind,
    input  logic [7:0]  din,
    output logic        last,
    output logic        bad,
    output logic [63:0] result
);

    logic [63:0] acc;
    logic [63:0] acc_n;
    logic [63:0] hi_mask;
    logic [63:0] sext;
    logic [3:0]  cnt;
    logic [6:0]  sh7;
    logic        is_leb;
    logic        at_cap;

    always_comb begin
        is_leb  = (kind == K_I32) || (kind == K_I64);
        at_cap  = (cnt == byte_limit(kind) - 4'd1);
        sh7     = 7'(cnt) * 7'd7;
        // Bits above the sign bit of this byte; empty past bit 63.
        hi_mask = {64{1'b1}} << (sh7 + 7'd7);
        if (is_leb) begin
            acc_n = acc | ({57'd0, din[6:0]} << sh7);
            last  = !din[7] || at_cap;
        end else begin
            acc_n = acc | ({56'd0, din} << {cnt, 3'b000});
            last  = at_cap;
        end
        sext = din[6] ? (acc_n | hi_mask) : (acc_n & ~hi_mask);
        unique case (kind)
            K_I32: result = {32'd0, sext[31:0]};
            K_I64: result = sext;
            K_F32: result = {32'd0, acc_n[31:0]};
            K_F64: result = acc_n;
        endcase
        bad = 1'b0;
`ifdef CONST_LEB_CHECK_EN
        if (is_leb && at_cap) begin
            if (din[7])
                bad = 1'b1;
            else if (kind == K_I32 && din[6:4] != {3{din[3]}})
                bad = 1'b1;
            else if (kind == K_I64 && din[6:1] != {6{din[0]}})
                bad = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (en) begin
            acc <= acc_n;
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/const_imm_fetch.sv
// const_imm_fetch: *.const sequencer - reads the immediate from ROM,
// pushes it to the operand stack and returns the next PC to decode.
// Ports: clk, reset (sync, active-high), bus (const_imm_fetch_if.slave).
// Option: CONST_LEB_CHECK_EN (malformed LEB trap, see leb128_accum).
module const_imm_fetch
    import cpu_pkg::*;
#(
    parameter int MAX_PC_W = 32
) (
    input logic               clk,
    input logic               reset,
    const_imm_fetch_if.slave  bus
);

    localparam logic [MAX_PC_W-1:0] PC_ONE =
        {{(MAX_PC_W-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_n;
    kind_t               kind_q;
    logic [MAX_PC_W-1:0] ptr;
    logic [MAX_PC_W-1:0] pc_q;
    logic [3:0]          rd_cnt;
    logic                rd_q;
    logic [63:0]         data_q;
    logic [2:0]          trap_q;
    logic                rd;
    logic                accept;
    logic                cons;
    logic                last;
    logic                bad;
    logic [63:0]         result;

    assign accept = (state == S_IDLE) && bus.start;
    // A byte is on rom_data exactly when a read was issued last cycle.
    assign cons   = (state == S_FETCH) && rd_q;

    leb128_accum u_accum (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (cons),
        .kind   (kind_q),
        .din    (bus.rom_data),
        .last   (last),
        .bad    (bad),
        .result (result)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        rd      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start)
                    state_n = op_valid(bus.opcode) ? S_FETCH : S_FINISH;
            end
            S_FETCH: begin
                // LEB keeps reading until the terminator is seen,
                // so one read past the last byte is discarded.
                rd = (rd_cnt < byte_limit(kind_q));
                if (cons && last)
                    state_n = bad ? S_FINISH : S_PUSH;
            end
            S_PUSH: begin
                if (bus.push_ready) state_n = S_FINISH;
            end
            S_FINISH: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q <= K_I32;
            ptr    <= '0;
            pc_q   <= '0;
            rd_cnt <= '0;
            rd_q   <= 1'b0;
            data_q <= '0;
            trap_q <= TRAP_NONE;
        end else begin
            rd_q <= rd;
            if (accept) begin
                kind_q <= op_kind(bus.opcode);
                ptr    <= bus.pc_in + PC_ONE;
                pc_q   <= bus.pc_in + PC_ONE;
                rd_cnt <= '0;
                trap_q <= op_valid(bus.opcode) ? TRAP_NONE
                                               : TRAP_BAD_OPCODE;
            end
            if (rd) begin
                ptr    <= ptr + PC_ONE;
                rd_cnt <= rd_cnt + 4'd1;
            end
            if (cons) begin
                pc_q <= pc_q + PC_ONE;
                if (last) begin
                    data_q <= result;
                    if (bad) trap_q <= TRAP_MALFORMED_LEB;
                end
            end
        end
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.rom_rd     = rd;
    assign bus.rom_addr   = rd ? ptr : '0;
    assign bus.push_valid = (state == S_PUSH);
    assign bus.push_data  = (state == S_PUSH) ? data_q : '0;
    assign bus.done       = (state == S_FINISH);
    assign bus.pc_out     = (state == S_FINISH) ? pc_q : '0;
    assign bus.trap       = (state == S_FINISH) ? trap_q : TRAP_NONE;

endmodule
